// File: rtl/cmd_cfg_pkg.sv
// cmd_cfg shared definitions: opcodes, response bytes
// and the command sequencer state type.
package cmd_cfg_pkg;

  localparam logic [7:0] STPTCH  = 8'h02;
  localparam logic [7:0] STRLL   = 8'h03;
  localparam logic [7:0] STYW    = 8'h04;
  localparam logic [7:0] STTHRST = 8'h05;
  localparam logic [7:0] CAL     = 8'h06;
  localparam logic [7:0] EMER    = 8'h07;
  localparam logic [7:0] MTSOFF  = 8'h08;

  localparam logic [7:0] RESP_ACK  = 8'hA5;
  localparam logic [7:0] RESP_NACK = 8'hEE;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MTR_WAIT,
    S_CAL,
    S_ACK,
    S_TX_WAIT
  } state_e;

endpackage

// File: rtl/cmd_cfg_spinup.sv
// Saturating spin-up timer; full_o marks the
// all-ones count and the count never wraps.
module spinup_timer #(
  parameter int W = 26
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic full_o
);

  logic [W-1:0] cnt_q, cnt_d;

  assign full_o = &cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (en_i && !full_o)
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/cmd_cfg.sv
// Host command decode: setpoint registers, motor
// spin-up / calibration sequencing, one-byte reply.
module cmd_cfg
  import cmd_cfg_pkg::*;
#(
  parameter bit         FAST_SIM = 1'b0,
  parameter logic [7:0] ACK      = RESP_ACK,
  parameter logic [7:0] NACK     = RESP_NACK
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_rdy,
  input  logic [7:0]         cmd,
  input  logic [15:0]        data,
  output logic               clr_cmd_rdy,
  output logic [7:0]         resp,
  output logic               send_resp,
  input  logic               resp_sent,
  output logic signed [15:0] d_ptch,
  output logic signed [15:0] d_roll,
  output logic signed [15:0] d_yaw,
  output logic [8:0]         thrst,
  output logic               strt_cal,
  output logic               inertial_cal,
  input  logic               cal_done,
  output logic               motors_off
);

  localparam int TW = FAST_SIM ? 9 : 26;

  state_e state_q, state_d;

  logic signed [15:0] ptch_q, ptch_d;
  logic signed [15:0] roll_q, roll_d;
  logic signed [15:0] yaw_q, yaw_d;
  logic [8:0]         thr_q, thr_d;
  logic [7:0]         resp_q, resp_d;
  logic               moff_q, moff_d;
  logic               ical_q, ical_d;

  logic tmr_clr, tmr_en, tmr_full;

  spinup_timer #(.W(TW)) u_tmr (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (tmr_clr),
    .en_i   (tmr_en),
    .full_o (tmr_full)
  );

  always_comb begin
    state_d     = state_q;
    ptch_d      = ptch_q;
    roll_d      = roll_q;
    yaw_d       = yaw_q;
    thr_d       = thr_q;
    resp_d      = resp_q;
    moff_d      = moff_q;
    ical_d      = ical_q;
    clr_cmd_rdy = 1'b0;
    send_resp   = 1'b0;
    strt_cal    = 1'b0;
    tmr_clr     = 1'b0;
    tmr_en      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (cmd_rdy) begin
          clr_cmd_rdy = 1'b1;
          resp_d      = ACK;
          state_d     = S_ACK;
          unique case (1'b1)
            (cmd == STPTCH):  ptch_d = $signed(data);
            (cmd == STRLL):   roll_d = $signed(data);
            (cmd == STYW):    yaw_d  = $signed(data);
            (cmd == STTHRST): thr_d  = data[8:0];
            (cmd == CAL): begin
              moff_d  = 1'b0;
              ical_d  = 1'b1;
              tmr_clr = 1'b1;
              state_d = S_MTR_WAIT;
            end
            (cmd == EMER): begin
              ptch_d = '0;
              roll_d = '0;
              yaw_d  = '0;
              thr_d  = '0;
            end
            (cmd == MTSOFF):  moff_d = 1'b1;
            default:          resp_d = NACK;
          endcase
        end
      end
      S_MTR_WAIT: begin
        tmr_en = 1'b1;
        if (tmr_full) begin
          strt_cal = 1'b1;
          state_d  = S_CAL;
        end
      end
      S_CAL: begin
        if (cal_done) begin
          ical_d  = 1'b0;
          state_d = S_ACK;
        end
      end
      S_ACK: begin
        send_resp = 1'b1;
        state_d   = S_TX_WAIT;
      end
      S_TX_WAIT: begin
        if (resp_sent)
          state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      ptch_q  <= '0;
      roll_q  <= '0;
      yaw_q   <= '0;
      thr_q   <= '0;
      resp_q  <= '0;
      moff_q  <= 1'b1;
      ical_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptch_q  <= ptch_d;
      roll_q  <= roll_d;
      yaw_q   <= yaw_d;
      thr_q   <= thr_d;
      resp_q  <= resp_d;
      moff_q  <= moff_d;
      ical_q  <= ical_d;
    end
  end

  assign d_ptch       = ptch_q;
  assign d_roll       = roll_q;
  assign d_yaw        = yaw_q;
  assign thrst        = thr_q;
  assign resp         = resp_q;
  assign motors_off   = moff_q;
  assign inertial_cal = ical_q;

endmodule

// File: tb/tb_cmd_cfg.sv
// Self-checking bench for cmd_cfg (FAST_SIM build):
// vector table, hand sequences, random commands vs model.
module tb_cmd_cfg;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_rdy;
  logic [7:0]  cmd;
  logic [15:0] data;
  logic        clr_cmd_rdy;
  logic [7:0]  resp;
  logic        send_resp;
  logic        resp_sent;
  logic [15:0] d_ptch;
  logic [15:0] d_roll;
  logic [15:0] d_yaw;
  logic [8:0]  thrst;
  logic        strt_cal;
  logic        inertial_cal;
  logic        cal_done;
  logic        motors_off;

  always #5 clk = ~clk;

  cmd_cfg #(.FAST_SIM(1'b1)) dut (
    .clk          (clk),
    .rst          (rst),
    .cmd_rdy      (cmd_rdy),
    .cmd          (cmd),
    .data         (data),
    .clr_cmd_rdy  (clr_cmd_rdy),
    .resp         (resp),
    .send_resp    (send_resp),
    .resp_sent    (resp_sent),
    .d_ptch       (d_ptch),
    .d_roll       (d_roll),
    .d_yaw        (d_yaw),
    .thrst        (thrst),
    .strt_cal     (strt_cal),
    .inertial_cal (inertial_cal),
    .cal_done     (cal_done),
    .motors_off   (motors_off)
  );

  int checks = 0;
  int errors = 0;

  // reference state of the setpoint registers
  logic [15:0] m_p, m_r, m_y;
  logic [8:0]  m_t;
  logic        m_moff;

  typedef struct {
    logic [7:0]  op;
    logic [15:0] d;
    logic [7:0]  rsp;
  } vec_t;

  vec_t tbl[9];

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit is_known(logic [7:0] op);
    return (op >= 8'h02) && (op <= 8'h08);
  endfunction

  function automatic void model_reset();
    m_p = '0; m_r = '0; m_y = '0; m_t = '0;
    m_moff = 1'b1;
  endfunction

  function automatic void model_apply(logic [7:0] op,
                                      logic [15:0] d);
    case (op)
      8'h02: m_p = d;
      8'h03: m_r = d;
      8'h04: m_y = d;
      8'h05: m_t = d[8:0];
      8'h06: m_moff = 1'b0;
      8'h07: begin
        m_p = '0; m_r = '0; m_y = '0; m_t = '0;
      end
      8'h08: m_moff = 1'b1;
      default: ;
    endcase
  endfunction

  task automatic chk_regs(string tag);
    chk({tag, "_ptch"}, 32'(d_ptch), 32'(m_p));
    chk({tag, "_roll"}, 32'(d_roll), 32'(m_r));
    chk({tag, "_yaw"}, 32'(d_yaw), 32'(m_y));
    chk({tag, "_thrst"}, 32'(thrst), 32'(m_t));
    chk({tag, "_moff"}, 32'(motors_off), 32'(m_moff));
  endtask

  task automatic finish_tx();
    repeat ($urandom_range(0, 3)) tick();
    resp_sent = 1'b1;
    tick();
    resp_sent = 1'b0;
  endtask

  // entered and left in an IDLE cycle, 1ns after the edge
  task automatic do_cmd(string tag, logic [7:0] op,
                        logic [15:0] d, logic [7:0] rsp);
    cmd = op; data = d; cmd_rdy = 1'b1;
    #1;
    chk({tag, "_clr"}, 32'(clr_cmd_rdy), 32'd1);
    chk({tag, "_early_send"}, 32'(send_resp), 32'd0);
    tick();
    cmd_rdy = 1'b0;
    model_apply(op, d);
    chk({tag, "_send"}, 32'(send_resp), 32'd1);
    chk({tag, "_resp"}, 32'(resp), 32'(rsp));
    chk({tag, "_clr_off"}, 32'(clr_cmd_rdy), 32'd0);
    chk_regs(tag);
    tick();
    chk({tag, "_send_1cyc"}, 32'(send_resp), 32'd0);
    finish_tx();
  endtask

  // runs 0x06 up to CAL; optionally completes calibration
  task automatic do_cal(string tag, bit complete);
    int k;
    int fired;
    cmd = 8'h06; data = 16'h0000; cmd_rdy = 1'b1;
    #1;
    chk({tag, "_clr"}, 32'(clr_cmd_rdy), 32'd1);
    tick();
    cmd_rdy = 1'b0;
    model_apply(8'h06, 16'h0000);
    chk({tag, "_moff"}, 32'(motors_off), 32'd0);
    chk({tag, "_ical"}, 32'(inertial_cal), 32'd1);
    chk({tag, "_nosend"}, 32'(send_resp), 32'd0);
    k = 1;
    fired = -1;
    while (fired < 0 && k <= 600) begin
      if (strt_cal) begin
        fired = k;
      end else begin
        cal_done = (k == 100);
        tick();
        k++;
      end
    end
    cal_done = 1'b0;
    chk({tag, "_strt_delay"}, 32'(fired), 32'd512);
    tick();
    chk({tag, "_strt_1cyc"}, 32'(strt_cal), 32'd0);
    chk({tag, "_ical_cal"}, 32'(inertial_cal), 32'd1);
    repeat (3) tick();
    chk({tag, "_cal_nosend"}, 32'(send_resp), 32'd0);
    if (complete) begin
      cal_done = 1'b1;
      tick();
      cal_done = 1'b0;
      chk({tag, "_ical_drop"}, 32'(inertial_cal), 32'd0);
      chk({tag, "_send"}, 32'(send_resp), 32'd1);
      chk({tag, "_resp"}, 32'(resp), 32'hA5);
      chk({tag, "_moff_on"}, 32'(motors_off), 32'd0);
      tick();
      finish_tx();
    end
  endtask

  initial begin
    rst = 1'b1; cmd_rdy = 1'b0; cmd = '0; data = '0;
    resp_sent = 1'b0; cal_done = 1'b0;
    model_reset();

    tbl[0] = '{8'h02, 16'h0100, 8'hA5};
    tbl[1] = '{8'h05, 16'hFFFF, 8'hA5};
    tbl[2] = '{8'h03, 16'h8000, 8'hA5};
    tbl[3] = '{8'h04, 16'h7FFF, 8'hA5};
    tbl[4] = '{8'h00, 16'h1234, 8'hEE};
    tbl[5] = '{8'hFF, 16'hBEEF, 8'hEE};
    tbl[6] = '{8'h05, 16'h0A03, 8'hA5};
    tbl[7] = '{8'h09, 16'h5555, 8'hEE};
    tbl[8] = '{8'h08, 16'h0000, 8'hA5};

    tick();
    tick();
    chk("rst_resp", 32'(resp), 32'd0);
    chk("rst_send", 32'(send_resp), 32'd0);
    chk("rst_clr", 32'(clr_cmd_rdy), 32'd0);
    chk("rst_strt", 32'(strt_cal), 32'd0);
    chk("rst_ical", 32'(inertial_cal), 32'd0);
    chk_regs("rst");
    rst = 1'b0;
    tick();

    for (int i = 0; i < 9; i++)
      do_cmd($sformatf("tbl%0d", i),
             tbl[i].op, tbl[i].d, tbl[i].rsp);

    // unknown opcode, then a packet held through TX_WAIT
    cmd = 8'h3C; data = 16'hCAFE; cmd_rdy = 1'b1;
    #1;
    chk("nack_clr", 32'(clr_cmd_rdy), 32'd1);
    tick();
    chk("nack_send", 32'(send_resp), 32'd1);
    chk("nack_resp", 32'(resp), 32'hEE);
    chk_regs("nack");
    cmd = 8'h02; data = 16'h1234;
    #1;
    chk("hold_ack_clr", 32'(clr_cmd_rdy), 32'd0);
    tick();
    chk("hold_tx_clr", 32'(clr_cmd_rdy), 32'd0);
    tick();
    resp_sent = 1'b1;
    #1;
    chk("hold_rs_clr", 32'(clr_cmd_rdy), 32'd0);
    tick();
    resp_sent = 1'b0;
    chk("hold_accept", 32'(clr_cmd_rdy), 32'd1);
    tick();
    cmd_rdy = 1'b0;
    model_apply(8'h02, 16'h1234);
    chk("hold_send", 32'(send_resp), 32'd1);
    chk("hold_resp", 32'(resp), 32'hA5);
    chk_regs("hold");
    tick();
    finish_tx();

    do_cal("cal", 1'b1);

    do_cmd("e_p", 8'h02, 16'hF00D, 8'hA5);
    do_cmd("e_r", 8'h03, 16'h0042, 8'hA5);
    do_cmd("e_y", 8'h04, 16'h9001, 8'hA5);
    do_cmd("e_t", 8'h05, 16'h00C8, 8'hA5);
    do_cmd("emer", 8'h07, 16'hFFFF, 8'hA5);
    chk("emer_moff_kept", 32'(motors_off), 32'd0);

    for (int n = 0; n < 40; n++) begin
      logic [7:0] op;
      logic [7:0] rb;
      int sel;
      sel = $urandom_range(0, 7);
      case (sel)
        0: op = 8'h02;
        1: op = 8'h03;
        2: op = 8'h04;
        3: op = 8'h05;
        4: op = 8'h07;
        5: op = 8'h08;
        default: begin
          rb = 8'($urandom);
          op = is_known(rb) ? 8'h40 : rb;
        end
      endcase
      do_cmd($sformatf("rnd%0d", n), op, 16'($urandom),
             is_known(op) ? 8'hA5 : 8'hEE);
    end

    do_cmd("pre_p", 8'h02, 16'h0777, 8'hA5);
    do_cal("rcal", 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_reset();
    chk("rcal_ical", 32'(inertial_cal), 32'd0);
    chk("rcal_send", 32'(send_resp), 32'd0);
    chk("rcal_resp", 32'(resp), 32'd0);
    chk_regs("rcal");
    cal_done = 1'b1;
    tick();
    cal_done = 1'b0;
    for (int j = 0; j < 3; j++) begin
      chk("late_cal_send", 32'(send_resp), 32'd0);
      chk("late_cal_ical", 32'(inertial_cal), 32'd0);
      tick();
    end
    do_cmd("post", 8'h04, 16'h0005, 8'hA5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
